// File: rtl/aes_dec_ctrl_if.sv
// ============================================================================
// aes_dec_ctrl_if : request/round-control bundle for the AES decrypt controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface aes_dec_ctrl_if #(
  parameter int CW = 2
) ();
  logic          start;
  logic          accept;
  logic [3:0]    rndNo;
  logic [CW-1:0] slot;
  logic          enbISR;
  logic          enbISB;
  logic          enbIMC;
  logic          enbAR;
  logic          enbKS;
  logic          kexp;
  logic          done;
  logic [9:0]    completed_round;

  modport master (
    output start,
    input  accept, rndNo, slot, enbISR, enbISB, enbIMC, enbAR, enbKS,
           kexp, done, completed_round
  );

  modport slave (
    input  start,
    output accept, rndNo, slot, enbISR, enbISB, enbIMC, enbAR, enbKS,
           kexp, done, completed_round
  );
endinterface

`default_nettype wire

// File: rtl/aes_dec_ctrl.sv
// ============================================================================
// aes_dec_ctrl : round/slot sequencer for an N-way interleaved AES decryptor
// Optional key-expansion phase: AES_DEC_KEYEXP_EN      Rev 1.0
// ============================================================================
`default_nettype none

module aes_dec_ctrl #(
  parameter int N  = 4,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rstn,
  aes_dec_ctrl_if.slave bus
);

  localparam logic [CW-1:0] c_SLOT_LAST = CW'(N - 1);
  localparam logic [3:0]    c_RND_TOP   = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
`ifdef AES_DEC_KEYEXP_EN
    S_KEYEXP = 2'd1,
`endif
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_nxt_state;
  logic [3:0]    r_rnd;
  logic [3:0]    w_nxt_rnd;
  logic [CW-1:0] r_slot;
  logic [CW-1:0] w_nxt_slot;
  logic          w_last_slot;

  logic          r_enb_isr, r_enb_isb, r_enb_imc, r_enb_ar, r_enb_ks, r_done;
  logic          w_enb_isr, w_enb_isb, w_enb_imc, w_enb_ar, w_enb_ks, w_done;
  logic [9:0]    r_cr;
  logic [9:0]    w_cr;
`ifdef AES_DEC_KEYEXP_EN
  logic          r_kexp;
  logic          w_kexp;
`endif

  assign w_last_slot = (r_slot == c_SLOT_LAST);

  // Next-state: slot free-runs within a round; the round index moves only on the last slot.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_rnd   = r_rnd;
    w_nxt_slot  = r_slot;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
`ifdef AES_DEC_KEYEXP_EN
          w_nxt_state = S_KEYEXP;
          w_nxt_rnd   = 4'd1;
`else
          w_nxt_state = S_RUN;
          w_nxt_rnd   = c_RND_TOP;
`endif
          w_nxt_slot  = '0;
        end
      end
`ifdef AES_DEC_KEYEXP_EN
      S_KEYEXP: begin
        if (!bus.start) begin
          w_nxt_state = S_IDLE;
          w_nxt_rnd   = 4'd0;
          w_nxt_slot  = '0;
        end else if (w_last_slot) begin
          w_nxt_slot = '0;
          if (r_rnd == c_RND_TOP) begin
            w_nxt_state = S_RUN;
            w_nxt_rnd   = c_RND_TOP;
          end else begin
            w_nxt_rnd = r_rnd + 4'd1;
          end
        end else begin
          w_nxt_slot = r_slot + 1'b1;
        end
      end
`endif
      S_RUN: begin
        if (!bus.start) begin
          w_nxt_state = S_IDLE;
          w_nxt_rnd   = 4'd0;
          w_nxt_slot  = '0;
        end else if (w_last_slot) begin
          w_nxt_slot = '0;
          if (r_rnd == 4'd0) begin
            w_nxt_state = S_DONE;
          end else begin
            w_nxt_rnd = r_rnd - 4'd1;
          end
        end else begin
          w_nxt_slot = r_slot + 1'b1;
        end
      end
      S_DONE: begin
        w_nxt_state = S_IDLE;
        w_nxt_rnd   = 4'd0;
        w_nxt_slot  = '0;
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_rnd   = 4'd0;
        w_nxt_slot  = '0;
      end
    endcase
  end

  // Output decode from the next state so the enables land in registers aligned with rndNo/slot.
  always_comb begin
    w_enb_isr = 1'b0;
    w_enb_isb = 1'b0;
    w_enb_imc = 1'b0;
    w_enb_ar  = 1'b0;
    w_enb_ks  = 1'b0;
    w_done    = 1'b0;
    w_cr      = '0;
`ifdef AES_DEC_KEYEXP_EN
    w_kexp    = 1'b0;
`endif
    case (w_nxt_state)
`ifdef AES_DEC_KEYEXP_EN
      S_KEYEXP: begin
        w_enb_ks = 1'b1;
        w_kexp   = 1'b1;
      end
`endif
      S_RUN: begin
        w_enb_ar  = 1'b1;
        w_enb_isr = (w_nxt_rnd <= 4'd9);
        w_enb_isb = (w_nxt_rnd <= 4'd9);
        w_enb_imc = (w_nxt_rnd != 4'd0) && (w_nxt_rnd <= 4'd9);
        w_enb_ks  = (w_nxt_rnd != 4'd0);
        if (w_nxt_rnd != 4'd0) begin
          w_cr = 10'd1 << (c_RND_TOP - w_nxt_rnd);
        end
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_rnd     <= 4'd0;
      r_slot    <= '0;
      r_enb_isr <= 1'b0;
      r_enb_isb <= 1'b0;
      r_enb_imc <= 1'b0;
      r_enb_ar  <= 1'b0;
      r_enb_ks  <= 1'b0;
      r_done    <= 1'b0;
      r_cr      <= '0;
`ifdef AES_DEC_KEYEXP_EN
      r_kexp    <= 1'b0;
`endif
    end else begin
      r_state   <= w_nxt_state;
      r_rnd     <= w_nxt_rnd;
      r_slot    <= w_nxt_slot;
      r_enb_isr <= w_enb_isr;
      r_enb_isb <= w_enb_isb;
      r_enb_imc <= w_enb_imc;
      r_enb_ar  <= w_enb_ar;
      r_enb_ks  <= w_enb_ks;
      r_done    <= w_done;
      r_cr      <= w_cr;
`ifdef AES_DEC_KEYEXP_EN
      r_kexp    <= w_kexp;
`endif
    end
  end

  // rstn gates accept so a request held through reset is not acknowledged early.
  assign bus.accept          = rstn & bus.start & (r_state == S_IDLE);
  assign bus.rndNo           = r_rnd;
  assign bus.slot            = r_slot;
  assign bus.enbISR          = r_enb_isr;
  assign bus.enbISB          = r_enb_isb;
  assign bus.enbIMC          = r_enb_imc;
  assign bus.enbAR           = r_enb_ar;
  assign bus.enbKS           = r_enb_ks;
  assign bus.done            = r_done;
  assign bus.completed_round = r_cr;
`ifdef AES_DEC_KEYEXP_EN
  assign bus.kexp            = r_kexp;
`else
  assign bus.kexp            = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_dec_ctrl.sv
// ============================================================================
// tb_aes_dec_ctrl : scoreboard bench for aes_dec_ctrl (N=4 and N=1 instances)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_aes_dec_ctrl;

  localparam int PER = 10;
`ifdef AES_DEC_KEYEXP_EN
  localparam int KE = 1;
`else
  localparam int KE = 0;
`endif
  localparam int P_IDLE = 0;
  localparam int P_ACC  = 1;
  localparam int P_KEY  = 2;
  localparam int P_RUN  = 3;
  localparam int P_DONE = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #(PER/2) clk = ~clk;

  aes_dec_ctrl_if #(.CW(2)) if4 ();
  aes_dec_ctrl_if #(.CW(1)) if1 ();

  aes_dec_ctrl #(.N(4)) u_dut4 (.clk(clk), .rstn(rstn), .bus(if4.slave));
  aes_dec_ctrl #(.N(1)) u_dut1 (.clk(clk), .rstn(rstn), .bus(if1.slave));

  typedef struct packed {
    logic       acc;
    logic [3:0] rnd;
    logic [1:0] slot;
    logic       isr, isb, imc, ar, ks, kexp, done;
    logic [9:0] cr;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs for one cycle, written straight from the round/enable table.
  function automatic exp_t rec(input int ph, input int r, input int s);
    exp_t e;
    e = '0;
    if (ph == P_ACC) e.acc = 1'b1;
    if (ph == P_KEY) begin
      e.rnd = 4'(r); e.slot = 2'(s); e.ks = 1'b1; e.kexp = 1'b1;
    end
    if (ph == P_RUN) begin
      e.rnd  = 4'(r); e.slot = 2'(s); e.ar = 1'b1;
      e.isr  = (r <= 9); e.isb = (r <= 9);
      e.imc  = (r >= 1 && r <= 9); e.ks = (r >= 1);
      if (r >= 1) e.cr = 10'(1 << (10 - r));
    end
    if (ph == P_DONE) e.done = 1'b1;
    return e;
  endfunction

  function automatic exp_t act4();
    exp_t e;
    e.acc = if4.accept; e.rnd = if4.rndNo; e.slot = if4.slot;
    e.isr = if4.enbISR; e.isb = if4.enbISB; e.imc = if4.enbIMC;
    e.ar = if4.enbAR; e.ks = if4.enbKS; e.kexp = if4.kexp;
    e.done = if4.done; e.cr = if4.completed_round;
    return e;
  endfunction

  function automatic exp_t act1();
    exp_t e;
    e.acc = if1.accept; e.rnd = if1.rndNo; e.slot = {1'b0, if1.slot};
    e.isr = if1.enbISR; e.isb = if1.enbISB; e.imc = if1.enbIMC;
    e.ar = if1.enbAR; e.ks = if1.enbKS; e.kexp = if1.kexp;
    e.done = if1.done; e.cr = if1.completed_round;
    return e;
  endfunction

  task automatic chk(input string nm, input exp_t a, input exp_t e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got{acc=%b rnd=%0d slot=%0d isr/isb/imc/ar/ks=%b%b%b%b%b kexp=%b done=%b cr=%b} exp{acc=%b rnd=%0d slot=%0d isr/isb/imc/ar/ks=%b%b%b%b%b kexp=%b done=%b cr=%b}",
               nm, cyc, a.acc, a.rnd, a.slot, a.isr, a.isb, a.imc, a.ar, a.ks, a.kexp, a.done, a.cr,
               e.acc, e.rnd, e.slot, e.isr, e.isb, e.imc, e.ar, e.ks, e.kexp, e.done, e.cr);
    end
  endtask

  // Monitors: pop one expected record per cycle; with nothing queued the block must be silent.
  always @(negedge clk) begin
    if (q4.size() != 0) chk("n4_trace", act4(), q4.pop_front());
    else                chk("n4_quiet", act4(), '0);
    if (q1.size() != 0) chk("n1_trace", act1(), q1.pop_front());
    else                chk("n1_quiet", act1(), '0);
  end

  task automatic push(input int inst, input exp_t e);
    if (inst == 4) q4.push_back(e);
    else           q1.push_back(e);
  endtask

  task automatic set_start(input int inst, input logic v);
    if (inst == 4) if4.start = v;
    else           if1.start = v;
  endtask

  // Queue the whole expected trace of one operation, optionally cut by an abort at (ab_r, ab_s).
  task automatic gen(input int inst, input int n, input int ab_r, input int ab_s);
    push(inst, rec(P_ACC, 0, 0));
    if (KE == 1)
      for (int r = 1; r <= 10; r++)
        for (int s = 0; s < n; s++) push(inst, rec(P_KEY, r, s));
    for (int r = 10; r >= 0; r--)
      for (int s = 0; s < n; s++) begin
        push(inst, rec(P_RUN, r, s));
        if (r == ab_r && s == ab_s) begin
          push(inst, rec(P_IDLE, 0, 0));
          return;
        end
      end
    push(inst, rec(P_DONE, 0, 0));
    push(inst, rec(P_IDLE, 0, 0));
  endtask

  task automatic run_full(input int inst, input int n);
    int l2;
    l2 = KE * 10 * n + 11 * n + 1;
    gen(inst, n, -1, -1);
    set_start(inst, 1'b1);
    repeat (l2) @(posedge clk);
    #1 set_start(inst, 1'b0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    if4.start = 1'b1;
    if1.start = 1'b1;
    #2 chk("rst_accept_gated_n4", act4(), '0);
    chk("rst_accept_gated_n1", act1(), '0);
    repeat (3) @(posedge clk);
    #1 if4.start = 1'b0; if1.start = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Full operation, N=4.
    run_full(4, 4);
    repeat (2) @(posedge clk);
    #1;

    // Abort at RUN rnd 5 slot 2, then a fresh request.
    k = 1 + KE * 40 + (10 - 5) * 4 + 2;
    gen(4, 4, 5, 2);
    if4.start = 1'b1;
    repeat (k) @(posedge clk);
    #1 if4.start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    run_full(4, 4);

    // Asynchronous reset mid-operation at round 7, slot 1.
    k = (KE == 1) ? (1 + 6 * 4 + 1) : (1 + 3 * 4 + 1);
    gen(4, 4, -1, -1);
    if4.start = 1'b1;
    repeat (k) @(posedge clk);
    #1 chk("pre_rst_rnd7", act4(), rec((KE == 1) ? P_KEY : P_RUN, 7, 1));
    #1 rstn = 1'b0;
    q4.delete();
    #1 chk("async_rst_clear", act4(), '0);
    @(posedge clk);
    #1 chk("rst_hold_edge", act4(), '0);
    rstn = 1'b1;
    run_full(4, 4);

    // Single-channel build: one cycle per round.
    run_full(1, 1);

    for (int i = 0; i < 20 && (q4.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    n_tests++;
    if (q4.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain got q4=%0d q1=%0d entries left, expected 0", q4.size(), q1.size());
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_dec_ctrl.md
AES_DEC_CTRL -- requirements
Module: aes_dec_ctrl

Interface
REQ-001 Parameter N, default 4, number of interleaved channels (cycles per round); legal N >= 1.
REQ-002 Parameter CW, default max(1, clog2(N)), width of the slot counter.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level request; held high for the whole operation; low means abort or idle.
REQ-006 accept  output  1  high while state==IDLE and start==1 (combinational); marks the acceptance cycle.
REQ-007 rndNo  output  4  round index: counts 1..10 up in KEYEXP, 10..0 down in RUN, else 0.
REQ-008 slot  output  CW  channel slot within the current round, 0..N-1.
REQ-009 enbISR, enbISB, enbIMC, enbAR  output  1 each  InvShiftRows, InvSubBytes, InvMixColumns and AddRoundKey datapath enables.
REQ-010 enbKS  output  1  key-schedule step enable.
REQ-011 kexp  output  1  high during the KEYEXP state; selects forward key-schedule direction.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 completed_round  output  10  one-hot round-progress vector.

Function
REQ-014 FSM states: IDLE, KEYEXP, RUN, DONE; state, rndNo and slot are registered.
REQ-015 IDLE with start==1 moves to KEYEXP (macro defined) or RUN (macro undefined); IDLE with start==0 stays in IDLE.
REQ-016 In KEYEXP and RUN, slot increments each cycle and wraps N-1 -> 0; the round advances only on the cycle slot==N-1.
REQ-017 KEYEXP enters with rndNo=1; the round step is rndNo+1; after rndNo==10, slot==N-1 the FSM enters RUN; KEYEXP lasts exactly 10*N cycles.
REQ-018 RUN enters with rndNo=10 and slot=0; the round step is rndNo-1; after rndNo==0, slot==N-1 the FSM enters DONE; RUN lasts exactly 11*N cycles.
REQ-019 DONE lasts one cycle with done=1, rndNo=0, slot=0, then always returns to IDLE; a new operation needs start sampled high in IDLE.
REQ-020 Enables in RUN: enbAR for all rndNo 10..0; enbISR and enbISB for rndNo<=9; enbIMC for 1<=rndNo<=9; enbKS (inverse step) for rndNo>=1.
REQ-021 Enables in KEYEXP: enbKS=1, kexp=1, all data enables 0.
REQ-022 In IDLE and DONE all enables are 0 and kexp is 0.
REQ-023 completed_round in RUN with rndNo in 10..1 is one-hot bit (10-rndNo); it is 0 in all other states and at rndNo==0.
REQ-024 Abort: start==0 in KEYEXP or RUN forces IDLE, rndNo=0 and slot=0 at the next edge, with no done pulse.
REQ-025 N==1: slot is constant 0 and every cycle advances the round.

Reset
REQ-026 rstn low asynchronously forces state=IDLE, rndNo=0, slot=0.
REQ-027 While rstn is low, accept=0, done=0, kexp=0, completed_round=0 and all enables are 0.
REQ-028 rstn deassertion mid-operation resumes from IDLE; if start is high, the first rising edge after deassertion is an acceptance.

Configuration
REQ-029 Macro AES_DEC_KEYEXP_EN defined: the controller runs the KEYEXP phase to derive the last round key from the cipher key before RUN.
REQ-030 Macro AES_DEC_KEYEXP_EN undefined: the KEYEXP state is not built, kexp is tied 0, IDLE goes directly to RUN, and the last round key is supplied externally.

Verification
REQ-031 N=4, macro on, start high from cycle c (accept=1 at c) -> KEYEXP cycles c+1..c+40, RUN c+41..c+84, done=1 only at c+85, IDLE at c+86.
REQ-032 N=4, macro off, start held high -> RUN c+1..c+44, done pulse at c+45; enbIMC=0 during rndNo 10 and rndNo 0.
REQ-033 N=4, start dropped at RUN rndNo=5, slot=2 -> next cycle IDLE, rndNo=0, slot=0, no done; re-raising start produces a fresh accept.
REQ-034 rstn pulsed low at KEYEXP rndNo=7 -> all outputs 0 immediately, without waiting for a clock edge; with start high, restart after release.
REQ-035 N=1, macro off -> rndNo sequence 10,9,...,0 on consecutive cycles; completed_round walks bit0..bit9; done on the 12th cycle after accept.
